// File: rtl/alu_exec_stage.sv
// ALU execute stage: computes one op per accepted upstream transfer and queues
// the result, flags and destination tag in a 2-entry buffer toward MEM.
module alu_exec_stage #(
    parameter int WIDTH = 32,
    parameter int REGW  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ALUctrlop,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic [REGW-1:0]  in_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_ovf,
    output logic             out_illegal,
    output logic [REGW-1:0]  out_rd
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             zero;
        logic             ovf;
        logic             illegal;
        logic [REGW-1:0]  rd;
    } entry_t;

    entry_t           new_e;
    entry_t           e0;
    entry_t           e1;
    entry_t           head;
    logic [1:0]       count;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             push;
    logic             pop;

    always_comb begin
        sum   = opA + opB;
        diff  = opA - opB;
        new_e = '0;
        case (ALUctrlop)
            OP_AND: new_e.result = opA & opB;
            OP_OR:  new_e.result = opA | opB;
            OP_ADD: begin
                new_e.result = sum;
                new_e.ovf    = (opA[WIDTH-1] == opB[WIDTH-1]) && (sum[WIDTH-1] != opA[WIDTH-1]);
            end
            OP_SUB: begin
                new_e.result = diff;
                new_e.ovf    = (opA[WIDTH-1] != opB[WIDTH-1]) && (diff[WIDTH-1] != opA[WIDTH-1]);
            end
            OP_SLT: new_e.result = {{(WIDTH-1){1'b0}}, ($signed(opA) < $signed(opB))};
            OP_NOR: new_e.result = ~(opA | opB);
            default: new_e.illegal = 1'b1;
        endcase
        new_e.zero = (new_e.result == '0);
        new_e.rd   = in_rd;
    end

    // Handshake: a transfer happens on an edge where valid && ready are both 1.
    // in_ready depends on buffer occupancy only, never on out_ready.
    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= 2'd0;
            e0    <= '0;
            e1    <= '0;
        end else if (flush) begin
            count <= 2'd0;
        end else if (push && pop) begin
            // Only reachable with one entry: the new op replaces the head.
            e0 <= new_e;
        end else if (push) begin
            if (count == 2'd0) e0 <= new_e;
            else               e1 <= new_e;
            count <= count + 2'd1;
        end else if (pop) begin
            e0    <= e1;
            count <= count - 2'd1;
        end
    end

    // Stale entry contents stay hidden behind out_valid.
    assign head        = out_valid ? e0 : '0;
    assign out_result  = head.result;
    assign out_zero    = head.zero;
    assign out_ovf     = head.ovf;
    assign out_illegal = head.illegal;
    assign out_rd      = head.rd;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: scoreboard queue of expected buffer entries, one
// task per scenario, inline comparisons against the queue head and constants.
module tb_alu_exec_stage;

    localparam int EW = 32 + 3 + 5;

    logic        clk = 0;
    logic        reset = 1;
    logic        flush = 0;
    logic        in_valid = 0;
    logic        in_ready;
    logic [3:0]  ALUctrlop = 0;
    logic [31:0] opA = 0;
    logic [31:0] opB = 0;
    logic [4:0]  in_rd = 0;
    logic        out_valid;
    logic        out_ready = 0;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_ovf;
    logic        out_illegal;
    logic [4:0]  out_rd;

    logic [EW-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    wire [EW+1:0] dut_vec = {out_valid, in_ready, out_result, out_zero, out_ovf, out_illegal, out_rd};

    alu_exec_stage #(.WIDTH(32), .REGW(5)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .ALUctrlop(ALUctrlop), .opA(opA), .opB(opB), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_zero(out_zero), .out_ovf(out_ovf),
        .out_illegal(out_illegal), .out_rd(out_rd)
    );

    always #5 clk = ~clk;

    // Reference: 33-bit sign-extended arithmetic gives overflow and SLT directly.
    function automatic logic [EW-1:0] model(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] rd);
        logic [32:0] ext;
        logic [31:0] r;
        logic        v;
        logic        ill;
        r = 0; v = 0; ill = 0;
        case (op)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: begin ext = {a[31], a} + {b[31], b}; r = ext[31:0]; v = ext[32] ^ ext[31]; end
            4'b0110: begin ext = {a[31], a} - {b[31], b}; r = ext[31:0]; v = ext[32] ^ ext[31]; end
            4'b0111: begin ext = {a[31], a} - {b[31], b}; r = {31'b0, ext[32]}; end
            4'b1100: r = ~(a | b);
            default: ill = 1;
        endcase
        return {r, (r == 32'd0), v, ill, rd};
    endfunction

    function automatic logic [EW+1:0] exp_vec();
        logic [EW-1:0] h;
        h = (exp_q.size() != 0) ? exp_q[0] : '0;
        return {exp_q.size() != 0, exp_q.size() < 2, h};
    endfunction

    task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
        in_valid = v; ALUctrlop = op; opA = a; opB = b; in_rd = rd;
    endtask

    // One clock: updates the scoreboard with the transfers the edge performs.
    task automatic advance();
        bit do_push;
        bit do_pop;
        logic [EW-1:0] e;
        do_push = in_valid && (exp_q.size() < 2);
        do_pop  = out_ready && (exp_q.size() != 0);
        e = model(ALUctrlop, opA, opB, in_rd);
        @(posedge clk);
        #1;
        if (flush) exp_q.delete();
        else begin
            if (do_pop)  void'(exp_q.pop_front());
            if (do_push) exp_q.push_back(e);
        end
    endtask

    task automatic test_reset();
        reset = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 0;
        exp_q.delete();
        advance();
        checks++;
        if ({out_valid, in_ready, out_result, out_zero} !== {1'b0, 1'b1, 32'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_idle: got v=%b rdy=%b res=%h z=%b, need v=0 rdy=1 res=0 z=0",
                     out_valid, in_ready, out_result, out_zero);
        end
    endtask

    task automatic test_ops();
        logic [3:0]  op_t [7] = '{4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1111, 4'b0000, 4'b0001};
        logic [31:0] a_t  [7] = '{32'h7FFFFFFF, 32'd5, 32'hFFFFFFFF, 32'd0, 32'h1234, 32'hF0F0F0F0, 32'h00FF0000};
        logic [31:0] b_t  [7] = '{32'd1, 32'd5, 32'd1, 32'd0, 32'h5678, 32'h0FF00FF0, 32'h000000FF};
        logic [31:0] r_t  [7] = '{32'h80000000, 32'd0, 32'd1, 32'hFFFFFFFF, 32'd0, 32'h00F000F0, 32'h00FF00FF};
        logic [2:0]  f_t  [7] = '{3'b010, 3'b100, 3'b000, 3'b000, 3'b101, 3'b000, 3'b000};
        out_ready = 1;
        for (int i = 0; i < 7; i++) begin
            drive(1, op_t[i], a_t[i], b_t[i], 5'(i + 3));
            advance();
            drive(0, 0, 0, 0, 0);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL op_model[%0d]: got %h, need %h", i, dut_vec, exp_vec());
            end
            checks++;
            if ({out_valid, out_result, out_zero, out_ovf, out_illegal, out_rd} !==
                {1'b1, r_t[i], f_t[i], 5'(i + 3)}) begin
                errors++;
                $display("FAIL op_const[%0d]: got v=%b res=%h z=%b o=%b i=%b rd=%0d, need res=%h zoi=%b rd=%0d",
                         i, out_valid, out_result, out_zero, out_ovf, out_illegal, out_rd, r_t[i], f_t[i], i + 3);
            end
            advance();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] got[$];
        bit accepted;
        out_ready = 0;
        drive(1, 4'b0000, 32'h0000F0F0, 32'h0000FF00, 5'd1);
        advance();
        drive(1, 4'b0001, 32'h0000F0F0, 32'h00000F0F, 5'd2);
        advance();
        drive(1, 4'b0010, 32'd2, 32'd3, 5'd3);
        advance();
        checks++;
        if ({in_ready, out_valid, out_result} !== {1'b0, 1'b1, 32'h0000F000} || dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL bp_full: got rdy=%b v=%b res=%h, need rdy=0 v=1 res=0000f000", in_ready, out_valid, out_result);
        end
        out_ready = 1;
        for (int c = 0; c < 4; c++) begin
            if (out_valid) got.push_back(out_result);
            accepted = in_valid && (exp_q.size() < 2);
            advance();
            if (accepted) drive(0, 0, 0, 0, 0);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL bp_drain[%0d]: got %h, need %h", c, dut_vec, exp_vec());
            end
        end
        checks++;
        if (got.size() != 3 || got[0] !== 32'h0000F000 || got[1] !== 32'h0000FFFF || got[2] !== 32'd5) begin
            errors++;
            $display("FAIL bp_order: got %0d results, need 3 results f000,ffff,5", got.size());
        end
    endtask

    task automatic test_push_pop();
        out_ready = 0;
        drive(1, 4'b0010, 32'd10, 32'd20, 5'd7);
        advance();
        drive(1, 4'b0110, 32'd3, 32'd9, 5'd9);
        out_ready = 1;
        advance();
        drive(0, 0, 0, 0, 0);
        out_ready = 0;
        checks++;
        if ({out_valid, in_ready, out_result, out_rd} !== {1'b1, 1'b1, 32'hFFFFFFFA, 5'd9} || dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL push_pop: got v=%b rdy=%b res=%h rd=%0d, need v=1 rdy=1 res=fffffffa rd=9",
                     out_valid, in_ready, out_result, out_rd);
        end
        out_ready = 1;
        advance();
    endtask

    task automatic test_flush();
        out_ready = 0;
        drive(1, 4'b0001, 32'd1, 32'd2, 5'd4);
        advance();
        advance();
        flush = 1;
        out_ready = 1;
        advance();
        flush = 0;
        drive(0, 0, 0, 0, 0);
        checks++;
        if ({out_valid, in_ready, out_result, out_rd} !== {1'b0, 1'b1, 32'd0, 5'd0} || dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL flush: got v=%b rdy=%b res=%h rd=%0d, need v=0 rdy=1 res=0 rd=0",
                     out_valid, in_ready, out_result, out_rd);
        end
    endtask

    task automatic test_async_reset();
        out_ready = 0;
        drive(1, 4'b0000, 32'hFFFF, 32'hFF, 5'd5);
        advance();
        advance();
        drive(0, 0, 0, 0, 0);
        #2 reset = 1;
        #1;
        checks++;
        if ({out_valid, in_ready, out_result, out_rd} !== {1'b0, 1'b1, 32'd0, 5'd0}) begin
            errors++;
            $display("FAIL async_reset: got v=%b rdy=%b res=%h rd=%0d, need v=0 rdy=1 res=0 rd=0",
                     out_valid, in_ready, out_result, out_rd);
        end
        exp_q.delete();
        @(negedge clk);
        reset = 0;
        drive(1, 4'b0010, 32'd1, 32'd1, 5'd6);
        out_ready = 1;
        advance();
        drive(0, 0, 0, 0, 0);
        checks++;
        if ({out_valid, out_result, out_rd} !== {1'b1, 32'd2, 5'd6} || dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL post_reset_push: got v=%b res=%h rd=%0d, need v=1 res=2 rd=6", out_valid, out_result, out_rd);
        end
        advance();
    endtask

    task automatic test_random();
        logic [3:0] codes[8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b0011, 4'b1111};
        for (int c = 0; c < 300; c++) begin
            drive($urandom_range(0, 3) != 0, codes[$urandom_range(0, 7)],
                  ($urandom_range(0, 3) == 0) ? 32'h7FFFFFFF : $urandom,
                  ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom, 5'($urandom_range(0, 31)));
            out_ready = $urandom_range(0, 2) != 0;
            flush = $urandom_range(0, 19) == 0;
            advance();
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL random[%0d]: got %h, need %h", c, dut_vec, exp_vec());
            end
        end
        flush = 0;
        drive(0, 0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_ops();
        test_backpressure();
        test_push_pop();
        test_flush();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
